// File: rtl/fmul_arbiter.sv
// Round-robin front end sharing one pipelined FP multiplier between two
// requesters, with per-requester 2-entry result FIFOs and credit flow control.
module fmul_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req0_rmode,
    input  logic [1:0]       req1_rmode,
    output logic             mul_valid,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [1:0]       mul_rmode,
    input  logic [WIDTH-1:0] mul_y,
    output logic             res0_valid,
    output logic             res1_valid,
    output logic [WIDTH-1:0] res0_y,
    output logic [WIDTH-1:0] res1_y,
    input  logic             res0_ready,
    input  logic             res1_ready,
    output logic             err
);

    logic [1:0]       cnt  [2];
    logic [1:0]       infl [2];
    logic [WIDTH-1:0] mem  [2][2];
    logic [1:0]       wp;
    logic [1:0]       rp;
    logic [LAT-1:0]   tag_v;
    logic [LAT-1:0]   tag_id;
    logic             ptr;
    logic             err_q;

    logic [1:0] elig;
    logic [1:0] grant;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] res_rdy;
    logic [1:0] ok;

    assign res_rdy = {res1_ready, res0_ready};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            ok[n] = ({1'b0, cnt[n]} + {1'b0, infl[n]}) < 3'd2;
            pop[n] = (cnt[n] != 2'd0) & res_rdy[n];
        end
        elig[0] = req0_valid & ok[0] & reset_n;
        elig[1] = req1_valid & ok[1] & reset_n;
        push[0] = tag_v[LAT-1] & ~tag_id[LAT-1];
        push[1] = tag_v[LAT-1] & tag_id[LAT-1];
    end

    // Pointer names the preferred requester; the other only wins when it idles
    always_comb begin
        grant = 2'b00;
        if (!ptr) begin
            grant[0] = elig[0];
            grant[1] = elig[1] & ~elig[0];
        end else begin
            grant[1] = elig[1];
            grant[0] = elig[0] & ~elig[1];
        end
    end

    always_comb begin
        mul_a     = '0;
        mul_b     = '0;
        mul_rmode = 2'b00;
        if (grant[0]) begin
            mul_a     = req0_a;
            mul_b     = req0_b;
            mul_rmode = req0_rmode;
        end else if (grant[1]) begin
            mul_a     = req1_a;
            mul_b     = req1_b;
            mul_rmode = req1_rmode;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign mul_valid  = |grant;
    assign res0_valid = cnt[0] != 2'd0;
    assign res1_valid = cnt[1] != 2'd0;
    assign res0_y     = res0_valid ? mem[0][rp[0]] : '0;
    assign res1_y     = res1_valid ? mem[1][rp[1]] : '0;
    assign err        = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr    <= 1'b0;
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            if (grant[0]) ptr <= 1'b1;
            else if (grant[1]) ptr <= 1'b0;
            tag_v[0]  <= |grant;
            tag_id[0] <= grant[1];
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= 2'b00;
            rp    <= 2'b00;
            err_q <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                cnt[n]    <= 2'd0;
                infl[n]   <= 2'd0;
                mem[n][0] <= '0;
                mem[n][1] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                infl[n] <= infl[n] + {1'b0, grant[n]} - {1'b0, push[n]};
                if (pop[n]) rp[n] <= ~rp[n];
                // A full FIFO only accepts a push when it is also popping
                if (push[n] && (cnt[n] != 2'd2 || pop[n])) begin
                    mem[n][wp[n]] <= mul_y;
                    wp[n]         <= ~wp[n];
                    if (!pop[n]) cnt[n] <= cnt[n] + 2'd1;
                end else begin
                    if (pop[n]) cnt[n] <= cnt[n] - 2'd1;
                    if (push[n]) err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter; a stub multiplier returns
// a + b - 0x3F800000 (exponent-add product for power-of-two style operands).
module tb_fmul_arbiter;

    localparam int W = 32;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_rmode, req1_rmode;
    logic         mul_valid;
    logic [W-1:0] mul_a, mul_b, mul_y;
    logic [1:0]   mul_rmode;
    logic         res0_valid, res1_valid;
    logic [W-1:0] res0_y, res1_y;
    logic         res0_ready, res1_ready;
    logic         err;

    int checks = 0;
    int failures = 0;

    fmul_arbiter #(.WIDTH(W), .LAT(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b),
        .req0_rmode(req0_rmode), .req1_rmode(req1_rmode),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_rmode(mul_rmode), .mul_y(mul_y),
        .res0_valid(res0_valid), .res1_valid(res1_valid),
        .res0_y(res0_y), .res1_y(res1_y),
        .res0_ready(res0_ready), .res1_ready(res1_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sp [L];
    always @(posedge clk) begin
        sp[0] <= mul_a + mul_b - 32'h3F800000;
        for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
    end
    assign mul_y = sp[L-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        req0_rmode = 0; req1_rmode = 0;
        res0_ready = 0; res1_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        req0_valid = 1; req1_valid = 1;
        req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0; req0_rmode = 2'd3;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        checks++;
        if (mul_valid !== 1'b0 || mul_a !== 0 || mul_b !== 0 || mul_rmode !== 0) begin
            failures++;
            $display("FAIL reset_mul got v=%b a=%h b=%h r=%h exp all zero",
                     mul_valid, mul_a, mul_b, mul_rmode);
        end
        checks++;
        if (res0_valid !== 0 || res1_valid !== 0 || res0_y !== 0 || res1_y !== 0 || err !== 0) begin
            failures++;
            $display("FAIL reset_res got v=%b%b y0=%h y1=%h err=%b exp zeros",
                     res0_valid, res1_valid, res0_y, res1_y, err);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000; req0_rmode = 2'd1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1 || mul_valid !== 1 || mul_a !== 32'h40000000 ||
            mul_b !== 32'h40400000 || mul_rmode !== 2'd1) begin
            failures++;
            $display("FAIL single_issue got rdy=%b v=%b a=%h b=%h r=%h exp 1 1 40000000 40400000 1",
                     req0_ready, mul_valid, mul_a, mul_b, mul_rmode);
        end
        tick();
        req0_valid = 0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (res0_valid !== 0) begin
            failures++;
            $display("FAIL single_early got=%b exp=0", res0_valid);
        end
        tick();
        res0_ready = 1;
        @(negedge clk);
        checks++;
        if (res0_valid !== 1 || res0_y !== 32'h40C00000) begin
            failures++;
            $display("FAIL single_result got v=%b y=%h exp v=1 y=40c00000", res0_valid, res0_y);
        end
        tick();
        res0_ready = 0;
        @(negedge clk);
        checks++;
        if (res0_valid !== 0 || res1_valid !== 0) begin
            failures++;
            $display("FAIL single_drain got=%b%b exp=00", res0_valid, res1_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e0, e1;
        e0 = 6'b000101;
        e1 = 6'b001010;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = 32'h40000000 + (c << 8); req0_b = 32'h40400000;
            req1_a = 32'h41000000 + (c << 8); req1_b = 32'h3F800000;
            @(negedge clk);
            checks++;
            if (req0_ready !== e0[c] || req1_ready !== e1[c]) begin
                failures++;
                $display("FAIL rr_cycle%0d got=%b%b exp=%b%b", c,
                         req0_ready, req1_ready, e0[c], e1[c]);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
        res0_ready = 1; res1_ready = 1;
        @(negedge clk);
        checks++;
        if (res0_y !== 32'h40C00000 || res1_y !== 32'h41000100 || !res0_valid || !res1_valid) begin
            failures++;
            $display("FAIL rr_first got y0=%h y1=%h exp 40c00000 41000100", res0_y, res1_y);
        end
        tick();
        @(negedge clk);
        checks++;
        if (res0_y !== 32'h40C00200 || res1_y !== 32'h41000300 || !res0_valid || !res1_valid) begin
            failures++;
            $display("FAIL rr_second got y0=%h y1=%h exp 40c00200 41000300", res0_y, res1_y);
        end
        tick();
        res0_ready = 0; res1_ready = 0;
        @(negedge clk);
        checks++;
        if (res0_valid !== 0 || res1_valid !== 0) begin
            failures++;
            $display("FAIL rr_drain got=%b%b exp=00", res0_valid, res1_valid);
        end
    endtask

    task automatic test_credit();
        int issues;
        issues = 0;
        do_reset();
        req1_valid = 1; req1_a = 32'h40000000; req1_b = 32'h3F800000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req1_ready === 1'b1) issues++;
            tick();
        end
        checks++;
        if (issues != 2) begin
            failures++;
            $display("FAIL credit_issues got=%0d exp=2", issues);
        end
        res1_ready = 1;
        @(negedge clk);
        checks++;
        if (req1_ready !== 0 || res1_valid !== 1) begin
            failures++;
            $display("FAIL credit_same_cycle got rdy=%b v=%b exp rdy=0 v=1", req1_ready, res1_valid);
        end
        tick();
        res1_ready = 0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1) begin
            failures++;
            $display("FAIL credit_freed got=%b exp=1", req1_ready);
        end
        tick();
        req1_valid = 0;
        @(negedge clk);
        checks++;
        if (err !== 0) begin
            failures++;
            $display("FAIL credit_err got=%b exp=0", err);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        tick();
        req0_a = 32'h40800000;
        tick();
        req0_valid = 0;
        tick();
        tick();
        res0_ready = 1;
        @(negedge clk);
        checks++;
        if (res0_valid !== 1 || res0_y !== 32'h40C00000) begin
            failures++;
            $display("FAIL pp_head0 got v=%b y=%h exp 1 40c00000", res0_valid, res0_y);
        end
        tick();
        res0_ready = 0;
        @(negedge clk);
        checks++;
        if (res0_valid !== 1 || res0_y !== 32'h41400000) begin
            failures++;
            $display("FAIL pp_head1 got v=%b y=%h exp 1 41400000", res0_valid, res0_y);
        end
        tick();
        res0_ready = 1;
        @(negedge clk);
        checks++;
        if (res0_valid !== 1 || res0_y !== 32'h41400000) begin
            failures++;
            $display("FAIL pp_hold got v=%b y=%h exp 1 41400000", res0_valid, res0_y);
        end
        tick();
        res0_ready = 0;
        @(negedge clk);
        checks++;
        if (res0_valid !== 0) begin
            failures++;
            $display("FAIL pp_count got v=%b exp 0", res0_valid);
        end
    endtask

    task automatic test_reset_inflight();
        logic [4:0] e0, e1;
        int bad;
        e0 = 5'b00101;
        e1 = 5'b01010;
        bad = 0;
        do_reset();
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'h40800000; req1_b = 32'h40000000;
        tick();
        reset_n = 0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 0 || mul_valid !== 0 || mul_a !== 0) begin
            failures++;
            $display("FAIL rst_mid_outputs got rdy=%b v=%b a=%h exp 0 0 0",
                     req1_ready, mul_valid, mul_a);
        end
        tick();
        reset_n = 1;
        req1_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (res0_valid !== 0 || res1_valid !== 0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_mid_stale got=%0d cycles with result valid exp=0", bad);
        end
        for (int c = 0; c < 5; c++) begin
            req0_valid = 1; req1_valid = 1;
            @(negedge clk);
            checks++;
            if (req0_ready !== e0[c] || req1_ready !== e1[c]) begin
                failures++;
                $display("FAIL rst_mid_grant%0d got=%b%b exp=%b%b", c,
                         req0_ready, req1_ready, e0[c], e1[c]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_credit();
        test_push_pop();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
